btn_conditioner: RTL and testbench

Front-end conditioner that turns raw, asynchronous, bouncing BASYS3 push-buttons into the clean, synchronous, single-cycle command pulses consumed by the stopwatch control FSM.
- Instantiated once at the top level, between the board pins and the control FSM.
- Bit mapping at the top level: bit 0 = reset button, bit 1 = trig, bit 2 = split.
- Each channel is synchronized, debounced by a per-channel stability counter, and edge-detected.
- Outputs are a debounced level and a one-clock press pulse.

---
 rtl/btn_conditioner_if.sv | 21 ++
 rtl/btn_conditioner.sv | 122 ++++++++++++
 tb/tb_btn_conditioner.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/btn_conditioner_if.sv
// Button bundle between the board pins and the stopwatch control logic.
// The conditioner drives the debounced level and the press pulse.
interface btn_conditioner_if #(
    parameter int N_BTN = 3
);
    logic [N_BTN-1:0] btn_in;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_pulse;

    modport master (
        output btn_in,
        input  btn_level,
        input  btn_pulse
    );

    modport slave (
        input  btn_in,
        output btn_level,
        output btn_pulse
    );
endinterface

// File: rtl/btn_conditioner.sv
// Per-channel synchronizer, stability-counter debouncer and press-edge detector.
// Produces a clean registered level and a one-clock pulse on each accepted press.
module btn_conditioner #(
    parameter int N_BTN           = 3,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18
) (
    input  logic              clk,
    input  logic              reset,
    btn_conditioner_if.slave  btn
);

    localparam logic [CNT_W-1:0] TERM = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        PEND_HI   = 2'd1,
        STABLE_HI = 2'd2,
        PEND_LO   = 2'd3
    } state_t;

    logic [N_BTN-1:0] sync1_q;
    logic [N_BTN-1:0] sync2_q;
    logic [N_BTN-1:0] level_vec;
    logic [N_BTN-1:0] pulse_vec;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn.btn_in;
            sync2_q <= sync1_q;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_BTN; gi++) begin : g_chan
            state_t           state_q;
            logic [CNT_W-1:0] cnt_q;
            logic             level_q;
            logic             pulse_q;

            // Leaving a stable state already counts that edge, so a window of
            // one cycle (TERM == 0) flips the level immediately.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    state_q <= STABLE_LO;
                    cnt_q   <= '0;
                    level_q <= 1'b0;
                    pulse_q <= 1'b0;
                end else begin
                    pulse_q <= 1'b0;
                    unique case (state_q)
                        STABLE_LO: begin
                            if (sync2_q[gi]) begin
                                if (TERM == '0) begin
                                    level_q <= 1'b1;
                                    pulse_q <= 1'b1;
                                    state_q <= STABLE_HI;
                                end else begin
                                    cnt_q   <= ONE;
                                    state_q <= PEND_HI;
                                end
                            end
                        end
                        PEND_HI: begin
                            if (!sync2_q[gi]) begin
                                cnt_q   <= '0;
                                state_q <= STABLE_LO;
                            end else if (cnt_q == TERM) begin
                                cnt_q   <= '0;
                                level_q <= 1'b1;
                                pulse_q <= 1'b1;
                                state_q <= STABLE_HI;
                            end else begin
                                cnt_q <= cnt_q + ONE;
                            end
                        end
                        STABLE_HI: begin
                            if (!sync2_q[gi]) begin
                                if (TERM == '0) begin
                                    level_q <= 1'b0;
                                    state_q <= STABLE_LO;
                                end else begin
                                    cnt_q   <= ONE;
                                    state_q <= PEND_LO;
                                end
                            end
                        end
                        PEND_LO: begin
                            if (sync2_q[gi]) begin
                                cnt_q   <= '0;
                                state_q <= STABLE_HI;
                            end else if (cnt_q == TERM) begin
                                cnt_q   <= '0;
                                level_q <= 1'b0;
                                state_q <= STABLE_LO;
                            end else begin
                                cnt_q <= cnt_q + ONE;
                            end
                        end
                        default: begin
                            cnt_q   <= '0;
                            level_q <= 1'b0;
                            state_q <= STABLE_LO;
                        end
                    endcase
                end
            end

            assign level_vec[gi] = level_q;
            assign pulse_vec[gi] = pulse_q;
        end
    endgenerate

    assign btn.btn_level = level_vec;
    assign btn.btn_pulse = pulse_vec;

endmodule

// File: tb/tb_btn_conditioner.sv
// Self-checking bench for btn_conditioner with a 4-cycle debounce window.
// Directed tables, corner-case sequences and random stimulus against a window-based model.
module tb_btn_conditioner;

    localparam int N   = 3;
    localparam int DEB = 4;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    btn_conditioner_if #(.N_BTN(N)) bus ();

    btn_conditioner #(
        .N_BTN(N),
        .DEBOUNCE_CYCLES(DEB),
        .CNT_W(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .btn(bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the level of a channel flips once the last DEB values
    // seen after the two-stage synchronizer all differ from the current level.
    logic [N-1:0] samp_q[$];
    logic [N-1:0] seen_q[$];
    logic [N-1:0] m_lvl;
    logic [N-1:0] m_pul;

    function automatic void model_reset();
        samp_q.delete();
        seen_q.delete();
        m_lvl = '0;
        m_pul = '0;
    endfunction

    function automatic void model_edge(logic [N-1:0] vin);
        logic [N-1:0] seen;
        logic [N-1:0] flip;
        int           diff;
        seen = (samp_q.size() >= 2) ? samp_q[samp_q.size()-2] : '0;
        samp_q.push_back(vin);
        if (samp_q.size() > 4) void'(samp_q.pop_front());
        seen_q.push_back(seen);
        if (seen_q.size() > DEB) void'(seen_q.pop_front());
        flip = '0;
        for (int c = 0; c < N; c++) begin
            diff = 0;
            foreach (seen_q[k]) if (seen_q[k][c] != m_lvl[c]) diff++;
            flip[c] = (seen_q.size() == DEB) && (diff == DEB);
        end
        m_pul = flip & ~m_lvl;
        m_lvl = m_lvl ^ flip;
    endfunction

    task automatic chk(string name, logic [N-1:0] act, logic [N-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk_int(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!reset) model_edge(bus.btn_in);
        #1;
        chk("model_level", bus.btn_level, m_lvl);
        chk("model_pulse", bus.btn_pulse, m_pul);
    endtask

    task automatic apply(logic [N-1:0] v);
        bus.btn_in = v;
        tick();
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) apply('0);
    endtask

    typedef struct {
        logic [N-1:0] vin;
        logic [N-1:0] lvl;
        logic [N-1:0] pul;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(logic [N-1:0] vin, logic [N-1:0] lvl, logic [N-1:0] pul);
        vec_t r;
        r.vin = vin;
        r.lvl = lvl;
        r.pul = pul;
        tbl.push_back(r);
    endfunction

    initial begin
        #1_000_000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        int           pulses;
        int           pedge;
        int           fall;
        logic [N-1:0] cur;
        int           run [N];

        // Clean press on channel 1, then release.
        for (int k = 0; k < 5; k++) add(3'b010, 3'b000, 3'b000);
        add(3'b010, 3'b010, 3'b010);
        add(3'b010, 3'b010, 3'b000);
        add(3'b010, 3'b010, 3'b000);
        for (int k = 0; k < 5; k++) add(3'b000, 3'b010, 3'b000);
        add(3'b000, 3'b000, 3'b000);
        add(3'b000, 3'b000, 3'b000);
        // Simultaneous press on channels 1 and 2, then release.
        for (int k = 0; k < 5; k++) add(3'b110, 3'b000, 3'b000);
        add(3'b110, 3'b110, 3'b110);
        add(3'b110, 3'b110, 3'b000);
        for (int k = 0; k < 5; k++) add(3'b000, 3'b110, 3'b000);
        add(3'b000, 3'b000, 3'b000);
        add(3'b000, 3'b000, 3'b000);

        bus.btn_in = '0;
        reset      = 1'b1;
        model_reset();
        #1;
        chk("reset_level", bus.btn_level, '0);
        chk("reset_pulse", bus.btn_pulse, '0);
        tick();
        tick();
        reset = 1'b0;
        idle(4);

        foreach (tbl[i]) begin
            apply(tbl[i].vin);
            chk($sformatf("tbl%0d_level", i), bus.btn_level, tbl[i].lvl);
            chk($sformatf("tbl%0d_pulse", i), bus.btn_pulse, tbl[i].pul);
        end

        // Bounce on channel 2: final rising sample at edge 4, pulse at edge 9.
        idle(4);
        pulses = 0;
        pedge  = -1;
        for (int e = 0; e < 16; e++) begin
            apply((e == 3) ? 3'b000 : 3'b100);
            if (bus.btn_pulse[2]) begin
                pulses++;
                pedge = e;
            end
        end
        chk_int("bounce_pulse_count", pulses, 1);
        chk_int("bounce_pulse_edge", pedge, 9);
        idle(8);

        // Hold channel 0 for 20 cycles, then release.
        pulses = 0;
        for (int e = 0; e < 20; e++) begin
            apply(3'b001);
            if (bus.btn_pulse[0]) pulses++;
        end
        fall = -1;
        for (int e = 0; e < 10; e++) begin
            apply(3'b000);
            if (bus.btn_pulse[0]) pulses++;
            if (fall < 0 && !bus.btn_level[0]) fall = e;
        end
        chk_int("hold_pulse_count", pulses, 1);
        chk_int("release_fall_edge", fall, 5);
        idle(4);

        // Reset after E3 with channel 1 held; pulse 6 edges after reset falls.
        for (int e = 0; e < 4; e++) apply(3'b010);
        reset = 1'b1;
        model_reset();
        #1;
        chk("midreset_level", bus.btn_level, '0);
        chk("midreset_pulse", bus.btn_pulse, '0);
        tick();
        tick();
        reset = 1'b0;
        pedge = -1;
        for (int e = 1; e <= 12; e++) begin
            apply(3'b010);
            if (pedge < 0 && bus.btn_pulse[1]) pedge = e;
        end
        chk_int("reset_release_pulse_edge", pedge, 6);

        // Asynchronous clear while level is high, away from any clock edge.
        chk("pre_async_level", bus.btn_level, 3'b010);
        #3;
        reset = 1'b1;
        model_reset();
        #1;
        chk("async_clear_level", bus.btn_level, '0);
        chk("async_clear_pulse", bus.btn_pulse, '0);
        tick();
        reset = 1'b0;
        idle(8);

        // Single-cycle glitch on channel 0 must be ignored.
        apply(3'b001);
        for (int e = 0; e < 8; e++) begin
            apply(3'b000);
            chk("glitch_level", bus.btn_level, '0);
            chk("glitch_pulse", bus.btn_pulse, '0);
        end
        pedge = -1;
        for (int e = 0; e < 10; e++) begin
            apply(3'b001);
            if (pedge < 0 && bus.btn_pulse[0]) pedge = e;
        end
        chk_int("post_glitch_press_edge", pedge, 5);
        idle(8);

        // Random runs on all channels with occasional resets.
        cur = '0;
        for (int c = 0; c < N; c++) run[c] = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int c = 0; c < N; c++) begin
                if (run[c] == 0) begin
                    cur[c] = 1'($urandom_range(0, 1));
                    run[c] = $urandom_range(1, 8);
                end
                run[c]--;
            end
            if ($urandom_range(0, 199) == 0) begin
                reset = 1'b1;
                model_reset();
                #1;
                chk("rand_reset_level", bus.btn_level, '0);
                chk("rand_reset_pulse", bus.btn_pulse, '0);
                tick();
                reset = 1'b0;
            end
            apply(cur);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
